// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: state encoding,
// branch-target table index width and the table contents.
package pc_seq_pkg;

  // Legacy-compatible state codes; the enum below uses the same values.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } pc_state_t;

  // Branch-target table index width; bit LUT_AW-1 selects absolute entries.
  localparam int LUT_AW = 3;

  // Relative offsets (indices 0..3), sign-extended to the PC width on use.
  localparam int REL_OFF0 = 3;
  localparam int REL_OFF1 = -4;
  localparam int REL_OFF2 = 8;
  localparam int REL_OFF3 = -13;

  // Absolute targets (indices 4..7), zero-extended to the PC width on use.
  localparam int ABS_TGT0 = 100;
  localparam int ABS_TGT1 = 200;
  localparam int ABS_TGT2 = 300;
  localparam int ABS_TGT3 = 400;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between decode, the PC sequencer and instruction ROM.
// The cycle_cnt signal exists only when PC_CYCLE_CNT_EN is defined.
interface pc_sequencer_if #(
  parameter int D = 12
`ifdef PC_CYCLE_CNT_EN
  , parameter int CNT_W = 16
`endif
) ();
  logic                            start;
  logic                            halt_req;
  logic                            stall;
  logic                            branch_en;
  logic [pc_seq_pkg::LUT_AW-1:0]   lut_addr;
  logic [D-1:0]                    pc;
  logic                            running;
  logic                            done;
`ifdef PC_CYCLE_CNT_EN
  logic [CNT_W-1:0]                cycle_cnt;
`endif

  // Controller side: drives requests, observes PC and status.
  modport master (
    output start, halt_req, stall, branch_en, lut_addr,
    input  pc, running, done
`ifdef PC_CYCLE_CNT_EN
    , input cycle_cnt
`endif
  );

  // Sequencer side.
  modport slave (
    input  start, halt_req, stall, branch_en, lut_addr,
    output pc, running, done
`ifdef PC_CYCLE_CNT_EN
    , output cycle_cnt
`endif
  );
endinterface

// File: rtl/pc_sequencer_lut.sv
// Combinational branch-target table: index -> D-bit target and absolute flag.
// Relative entries come out as D-bit two's complement, absolute ones zero-extended.
module branch_target_lut
  import pc_seq_pkg::*;
#(
  parameter int D = 12
) (
  input  logic [LUT_AW-1:0] i_lut_addr,
  output logic [D-1:0]      o_target,
  output logic              o_is_abs
);

  // Table lookup; truncation to D bits yields the two's-complement form.
  always_comb begin
    o_target = '0;
    case (i_lut_addr)
      3'd0:    o_target = D'(REL_OFF0);
      3'd1:    o_target = D'(REL_OFF1);
      3'd2:    o_target = D'(REL_OFF2);
      3'd3:    o_target = D'(REL_OFF3);
      3'd4:    o_target = D'(ABS_TGT0);
      3'd5:    o_target = D'(ABS_TGT1);
      3'd6:    o_target = D'(ABS_TGT2);
      default: o_target = D'(ABS_TGT3);
    endcase
  end

  assign o_is_abs = i_lut_addr[LUT_AW-1];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE handshake, next-PC selection with
// halt > stall > branch > increment priority, all outputs registered.
// Optional RUN-cycle counter enabled by defining PC_CYCLE_CNT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D          = 12,
  parameter int START_ADDR = 0
`ifdef PC_CYCLE_CNT_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);

  pc_state_t    r_state;
  logic [D-1:0] r_pc;
  logic         r_running;
  logic         r_done;

  logic [D-1:0] w_target;
  logic         w_is_abs;
  logic [D-1:0] w_pc_next;
  logic         w_start_ok;

  branch_target_lut #(.D(D)) u_lut (
    .i_lut_addr (bus.lut_addr),
    .o_target   (w_target),
    .o_is_abs   (w_is_abs)
  );

  // start is honoured only from IDLE or DONE.
  assign w_start_ok = bus.start && (r_state != RUN);

  // RUN-state next PC (halt is handled by the state logic, which leaves PC alone).
  always_comb begin
    w_pc_next = r_pc + D'(1);
    if (bus.stall)
      w_pc_next = r_pc;
    else if (bus.branch_en)
      w_pc_next = w_is_abs ? w_target : (r_pc + w_target);
  end

  // State, PC and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= START_PC;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.halt_req) begin
            r_state   <= DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_pc <= w_pc_next;
          end
        end
        default: begin
          if (w_start_ok) begin
            r_state   <= RUN;
            r_pc      <= START_PC;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pc      = r_pc;
  assign bus.running = r_running;
  assign bus.done    = r_done;

`ifdef PC_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  // Saturating count of RUN cycles (stall and halt cycles included).
  always_ff @(posedge clk) begin
    if (reset)
      r_cycle_cnt <= '0;
    else if (w_start_ok)
      r_cycle_cnt <= '0;
    else if ((r_state == RUN) && (r_cycle_cnt != {CNT_W{1'b1}}))
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
  end

  assign bus.cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (D=12, START_ADDR=0, CNT_W=4 when the
// cycle counter is built in). Inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

`ifdef PC_CYCLE_CNT_EN
  pc_sequencer_if #(.D(12), .CNT_W(4)) bus ();
  pc_sequencer #(.D(12), .START_ADDR(0), .CNT_W(4)) dut (
    .clk (clk), .reset (reset), .bus (bus)
  );
`else
  pc_sequencer_if #(.D(12)) bus ();
  pc_sequencer #(.D(12), .START_ADDR(0)) dut (
    .clk (clk), .reset (reset), .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.halt_req = 0; bus.stall = 0; bus.branch_en = 0; bus.lut_addr = '0;
  endtask

  task automatic do_start();
    bus.start = 1; tick(); bus.start = 0;
  endtask

  task automatic branch(input logic [2:0] idx);
    bus.branch_en = 1; bus.lut_addr = idx; tick(); bus.branch_en = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; tick(); reset = 0;
    checks++; if (bus.pc !== 12'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", bus.pc); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    tick(); tick();
    checks++; if (bus.pc !== 12'd0 || bus.running !== 1'b0) begin failures++; $display("FAIL idle_hold pc=%0d run=%b exp 0/0", bus.pc, bus.running); end
  endtask

  task automatic test_run_sequence();
    do_start();
    checks++; if (bus.pc !== 12'd0 || bus.running !== 1'b1 || bus.done !== 1'b0) begin
      failures++; $display("FAIL start_state pc=%0d run=%b done=%b exp 0/1/0", bus.pc, bus.running, bus.done); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (bus.pc !== 12'(i)) begin failures++; $display("FAIL incr_seq got=%0d exp=%0d", bus.pc, i); end
    end
    checks++; if (bus.running !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL run_flags run=%b done=%b exp 1/0", bus.running, bus.done); end
  endtask

  task automatic test_relative_branch();
    repeat (5) tick();   // pc 5 -> 10
    checks++; if (bus.pc !== 12'd10) begin failures++; $display("FAIL reach10 got=%0d exp=10", bus.pc); end
    branch(3'd1);
    checks++; if (bus.pc !== 12'd6) begin failures++; $display("FAIL rel_m4 got=%0d exp=6", bus.pc); end
    branch(3'd1);
    checks++; if (bus.pc !== 12'd2) begin failures++; $display("FAIL rel_m4b got=%0d exp=2", bus.pc); end
    branch(3'd3);
    checks++; if (bus.pc !== 12'd4085) begin failures++; $display("FAIL rel_wrap got=%0d exp=4085", bus.pc); end
    repeat (10) tick();
    checks++; if (bus.pc !== 12'd4095) begin failures++; $display("FAIL reach4095 got=%0d exp=4095", bus.pc); end
    tick();
    checks++; if (bus.pc !== 12'd0) begin failures++; $display("FAIL incr_wrap got=%0d exp=0", bus.pc); end
  endtask

  task automatic test_absolute_stall();
    repeat (7) tick();
    bus.stall = 1; bus.branch_en = 1; bus.lut_addr = 3'd6; tick(); bus.stall = 0; bus.branch_en = 0;
    checks++; if (bus.pc !== 12'd7) begin failures++; $display("FAIL stall_over_branch got=%0d exp=7", bus.pc); end
    bus.stall = 1; tick(); tick(); bus.stall = 0;
    checks++; if (bus.pc !== 12'd7) begin failures++; $display("FAIL stall_hold got=%0d exp=7", bus.pc); end
    branch(3'd6);
    checks++; if (bus.pc !== 12'd300) begin failures++; $display("FAIL abs_300 got=%0d exp=300", bus.pc); end
    branch(3'd4);
    checks++; if (bus.pc !== 12'd100) begin failures++; $display("FAIL abs_100 got=%0d exp=100", bus.pc); end
    branch(3'd5);
    checks++; if (bus.pc !== 12'd200) begin failures++; $display("FAIL abs_200 got=%0d exp=200", bus.pc); end
    branch(3'd7);
    checks++; if (bus.pc !== 12'd400) begin failures++; $display("FAIL abs_400 got=%0d exp=400", bus.pc); end
    branch(3'd0);
    checks++; if (bus.pc !== 12'd403) begin failures++; $display("FAIL rel_p3 got=%0d exp=403", bus.pc); end
    branch(3'd2);
    checks++; if (bus.pc !== 12'd411) begin failures++; $display("FAIL rel_p8 got=%0d exp=411", bus.pc); end
    bus.start = 1; tick(); bus.start = 0;
    checks++; if (bus.pc !== 12'd412 || bus.running !== 1'b1) begin failures++; $display("FAIL start_in_run pc=%0d run=%b exp 412/1", bus.pc, bus.running); end
  endtask

  task automatic test_halt();
    logic [2:0]  path [10];
    logic [11:0] want [10];
    path = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd0};
    want = '{12'd100, 12'd87, 12'd74, 12'd61, 12'd48, 12'd35, 12'd22, 12'd9, 12'd17, 12'd20};
    for (int i = 0; i < 10; i++) begin
      branch(path[i]);
      checks++; if (bus.pc !== want[i]) begin failures++; $display("FAIL path_to_20 step=%0d got=%0d exp=%0d", i, bus.pc, want[i]); end
    end
    bus.halt_req = 1; bus.branch_en = 1; bus.lut_addr = 3'd6; bus.start = 1; tick();
    bus.halt_req = 0; bus.branch_en = 0; bus.start = 0;
    checks++; if (bus.pc !== 12'd20 || bus.done !== 1'b1 || bus.running !== 1'b0) begin
      failures++; $display("FAIL halt pc=%0d done=%b run=%b exp 20/1/0", bus.pc, bus.done, bus.running); end
    for (int i = 0; i < 10; i++) begin
      bus.branch_en = i[0]; bus.stall = i[1]; bus.halt_req = i[2]; bus.lut_addr = 3'd5;
      tick();
      checks++; if (bus.pc !== 12'd20 || bus.done !== 1'b1) begin failures++; $display("FAIL done_hold cyc=%0d pc=%0d done=%b exp 20/1", i, bus.pc, bus.done); end
    end
    idle_inputs();
    do_start();
    checks++; if (bus.pc !== 12'd0 || bus.done !== 1'b0 || bus.running !== 1'b1) begin
      failures++; $display("FAIL restart pc=%0d done=%b run=%b exp 0/0/1", bus.pc, bus.done, bus.running); end
    tick();
    checks++; if (bus.pc !== 12'd1) begin failures++; $display("FAIL restart_incr got=%0d exp=1", bus.pc); end
  endtask

  task automatic test_reset_midrun();
    repeat (49) tick();
    checks++; if (bus.pc !== 12'd50) begin failures++; $display("FAIL reach50 got=%0d exp=50", bus.pc); end
    reset = 1; bus.branch_en = 1; bus.lut_addr = 3'd7; tick(); reset = 0; bus.branch_en = 0;
    checks++; if (bus.pc !== 12'd0 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_midrun pc=%0d run=%b done=%b exp 0/0/0", bus.pc, bus.running, bus.done); end
    bus.halt_req = 1; bus.stall = 1; bus.branch_en = 1; tick(); tick();
    idle_inputs();
    checks++; if (bus.pc !== 12'd0 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL halt_in_idle pc=%0d run=%b done=%b exp 0/0/0", bus.pc, bus.running, bus.done); end
  endtask

`ifdef PC_CYCLE_CNT_EN
  task automatic test_cycle_cnt();
    do_start();
    checks++; if (bus.cycle_cnt !== 4'd0) begin failures++; $display("FAIL cnt_start got=%0d exp=0", bus.cycle_cnt); end
    bus.stall = 1; repeat (3) tick(); bus.stall = 0;
    checks++; if (bus.cycle_cnt !== 4'd3) begin failures++; $display("FAIL cnt_stall got=%0d exp=3", bus.cycle_cnt); end
    bus.halt_req = 1; tick(); bus.halt_req = 0;
    repeat (2) tick();
    checks++; if (bus.cycle_cnt !== 4'd4) begin failures++; $display("FAIL cnt_done_hold got=%0d exp=4", bus.cycle_cnt); end
    do_start();
    checks++; if (bus.cycle_cnt !== 4'd0) begin failures++; $display("FAIL cnt_clear got=%0d exp=0", bus.cycle_cnt); end
    repeat (20) tick();
    checks++; if (bus.cycle_cnt !== 4'd15) begin failures++; $display("FAIL cnt_sat got=%0d exp=15", bus.cycle_cnt); end
    bus.halt_req = 1; tick(); bus.halt_req = 0;
    do_start();
    checks++; if (bus.cycle_cnt !== 4'd0) begin failures++; $display("FAIL cnt_restart got=%0d exp=0", bus.cycle_cnt); end
  endtask
`endif

  initial begin
    checks = 0; failures = 0; reset = 1;
    idle_inputs();
    test_reset();
    test_run_sequence();
    test_relative_branch();
    test_absolute_stall();
    test_halt();
    test_reset_midrun();
`ifdef PC_CYCLE_CNT_EN
    test_cycle_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
